// File: rtl/ioctl_sdram_pump.sv
// Packs ioctl download bytes into 16-bit SDRAM writes through a small FIFO.
// Optional `IOCTL_PROM_EN routes bytes at or above PROM_START to a byte-wide PROM port.
module ioctl_sdram_pump #(
    parameter int unsigned FIFO_AW    = 3,
    parameter logic [24:0] PROM_START = 25'h1F0_0000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        prog_req,
    input  logic        prog_ack,
    output logic [23:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_be,
    output logic        prom_we,
    output logic [24:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    typedef enum logic [1:0] {StIdle, StHold, StFlush2} pack_state_e;

    pack_state_e state_q, state_d;
    logic        wr_q, dl_q, busy_q, overflow_q;
    logic        accept, dl_rise, dl_fall, byte_prom;
    logic [23:0] hold_addr_q, hold_addr_d;
    logic [7:0]  hold_lo_q, hold_lo_d;
    logic [24:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;

    logic        take_v;
    logic [24:0] take_a;
    logic [7:0]  take_d;
    logic        push, push_ok, pop, fifo_empty, fifo_full;
    logic [41:0] push_entry, head;
    logic [41:0] mem_q [Depth];
    logic [FIFO_AW:0] wptr_q, rptr_q;

    logic        req_q;
    logic [23:0] req_addr_q;
    logic [15:0] req_data_q;
    logic [1:0]  req_be_q;

    always_comb begin
        accept  = ioctl_wr & ~wr_q & ioctl_download;
        dl_rise = ioctl_download & ~dl_q;
        dl_fall = ~ioctl_download & dl_q;
`ifdef IOCTL_PROM_EN
        byte_prom = (ioctl_addr >= PROM_START);
`else
        byte_prom = 1'b0;
`endif
    end

    // Packer: a byte either completes/starts a word or forces out the held half word.
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_lo_d   = hold_lo_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        push        = 1'b0;
        push_entry  = '0;
        take_v      = 1'b0;
        take_a      = ioctl_addr;
        take_d      = ioctl_dout;
        unique case (state_q)
            StIdle: take_v = accept & ~byte_prom;
            StHold: begin
                if (accept) begin
                    push = 1'b1;
                    if (!byte_prom && ioctl_addr[0] && ioctl_addr[24:1] == hold_addr_q) begin
                        push_entry = {hold_addr_q, ioctl_dout, hold_lo_q, 2'b11};
                        state_d    = StIdle;
                    end else begin
                        push_entry = {hold_addr_q, 8'h00, hold_lo_q, 2'b01};
                        if (byte_prom) begin
                            state_d = StIdle;
                        end else begin
                            pend_addr_d = ioctl_addr;
                            pend_data_d = ioctl_dout;
                            state_d     = StFlush2;
                        end
                    end
                end else if (dl_fall) begin
                    push       = 1'b1;
                    push_entry = {hold_addr_q, 8'h00, hold_lo_q, 2'b01};
                    state_d    = StIdle;
                end
            end
            StFlush2: begin
                take_v = 1'b1;
                take_a = pend_addr_q;
                take_d = pend_data_q;
            end
            default: state_d = StIdle;
        endcase
        if (take_v) begin
            if (take_a[0]) begin
                push       = 1'b1;
                push_entry = {take_a[24:1], take_d, 8'h00, 2'b10};
                state_d    = StIdle;
            end else if (dl_fall) begin
                // Download ended while the pending even byte was being replayed.
                push       = 1'b1;
                push_entry = {take_a[24:1], 8'h00, take_d, 2'b01};
                state_d    = StIdle;
            end else begin
                hold_addr_d = take_a[24:1];
                hold_lo_d   = take_d;
                state_d     = StHold;
            end
        end
    end

    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
        pop        = req_q & prog_ack;
        push_ok    = push & (~fifo_full | pop);
        head       = mem_q[rptr_q[FIFO_AW-1:0]];
        busy       = ioctl_download | (state_q != StIdle) | ~fifo_empty | req_q;
        done       = busy_q & ~busy;
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem_q[wptr_q[FIFO_AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            dl_q        <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_lo_q   <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            req_q       <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= ioctl_wr;
            dl_q        <= ioctl_download;
            busy_q      <= busy;
            hold_addr_q <= hold_addr_d;
            hold_lo_q   <= hold_lo_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (dl_rise) begin
                overflow_q <= 1'b0;
            end
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            // Head is registered at request time and held until the ack pops it.
            if (pop) begin
                req_q <= 1'b0;
            end else if (!req_q && !fifo_empty) begin
                req_q      <= 1'b1;
                req_addr_q <= head[41:18];
                req_data_q <= head[17:2];
                req_be_q   <= head[1:0];
            end
        end
    end

    assign prog_req  = req_q;
    assign prog_addr = req_addr_q;
    assign prog_data = req_data_q;
    assign prog_be   = req_be_q;
    assign overflow  = overflow_q;

`ifdef IOCTL_PROM_EN
    logic        prom_we_q;
    logic [24:0] prom_addr_q;
    logic [7:0]  prom_data_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            prom_we_q   <= 1'b0;
            prom_addr_q <= '0;
            prom_data_q <= '0;
        end else begin
            prom_we_q <= accept & byte_prom;
            if (accept && byte_prom) begin
                prom_addr_q <= ioctl_addr - PROM_START;
                prom_data_q <= ioctl_dout;
            end
        end
    end

    assign prom_we   = prom_we_q;
    assign prom_addr = prom_addr_q;
    assign prom_data = prom_data_q;
`else
    logic unused_prom_start;
    assign unused_prom_start = ^PROM_START;
    assign prom_we   = 1'b0;
    assign prom_addr = '0;
    assign prom_data = '0;
`endif

endmodule

// File: tb/tb_ioctl_sdram_pump.sv
// Directed bench for ioctl_sdram_pump; SDRAM writes and PROM pulses are logged at negedge.
module tb_ioctl_sdram_pump;

    localparam logic [24:0] PromStart = 25'd16;
`ifdef IOCTL_PROM_EN
    localparam logic ExpOvf = 1'b0;  // bytes 16..19 of the long burst go to the PROM
`else
    localparam logic ExpOvf = 1'b1;
`endif

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        prog_req;
    logic        prog_ack = 1'b0;
    logic [23:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_be;
    logic        prom_we;
    logic [24:0] prom_addr;
    logic [7:0]  prom_data;
    logic        busy, done, overflow;

    always #5 clk_sys = ~clk_sys;

    ioctl_sdram_pump #(
        .FIFO_AW    (3),
        .PROM_START (PromStart)
    ) dut (
        .clk_sys        (clk_sys),
        .rst            (rst),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .prog_req       (prog_req),
        .prog_ack       (prog_ack),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .prog_be        (prog_be),
        .prom_we        (prom_we),
        .prom_addr      (prom_addr),
        .prom_data      (prom_data),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        ack_en = 1'b1;
    logic [41:0] wr_log [$];
    int          done_cnt = 0;
    int          prom_cnt = 0;
    logic [24:0] prom_a_seen = '0;
    logic [7:0]  prom_d_seen = '0;
    logic        watch = 1'b0;
    logic        req_seen = 1'b0;
    logic [41:0] snap = '0;
    int          unstable = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM responder: ack one cycle after a request is seen, logging the written entry.
    always @(negedge clk_sys) begin
        if (done) done_cnt++;
        if (prom_we) begin
            prom_cnt++;
            prom_a_seen = prom_addr;
            prom_d_seen = prom_data;
        end
        if (watch) begin
            if (req_seen && (!prog_req || {prog_addr, prog_data, prog_be} != snap)) unstable++;
            if (prog_req && !req_seen) begin
                req_seen = 1'b1;
                snap     = {prog_addr, prog_data, prog_be};
            end
        end
        if (prog_req && ack_en && !prog_ack) begin
            prog_ack = 1'b1;
            wr_log.push_back({prog_addr, prog_data, prog_be});
        end else begin
            prog_ack = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic set_dl(input logic v);
        @(negedge clk_sys);
        ioctl_download = v;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (busy && i < 300) begin
            @(negedge clk_sys);
            i++;
        end
        check_eq(tag, busy, 1'b0);
        tick(2);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [41:0] exp);
        logic [41:0] got;
        got = (idx < wr_log.size()) ? wr_log[idx] : 'x;
        check_eq(tag, got, exp);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        check_eq("rst_req", prog_req, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_prom_we", prom_we, 1'b0);
        rst = 1'b0;
        tick(2);

        // Four sequential bytes pack into two full words
        wr_log.delete();
        done_cnt = 0;
        set_dl(1'b1);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        send_byte(25'd2, 8'h33);
        send_byte(25'd3, 8'h44);
        set_dl(1'b0);
        drain("t1_drain");
        check_eq("t1_count", wr_log.size(), 2);
        check_log("t1_w0", 0, {24'd0, 16'h2211, 2'b11});
        check_log("t1_w1", 1, {24'd1, 16'h4433, 2'b11});
        check_eq("t1_done", done_cnt, 1);

        // Lone even byte flushed by the download falling edge
        wr_log.delete();
        done_cnt = 0;
        set_dl(1'b1);
        send_byte(25'd4, 8'hAA);
        set_dl(1'b0);
        drain("t2_drain");
        check_eq("t2_count", wr_log.size(), 1);
        check_log("t2_w0", 0, {24'd2, 16'h00AA, 2'b01});
        check_eq("t2_done", done_cnt, 1);

        // Even byte followed by an unrelated odd byte
        wr_log.delete();
        set_dl(1'b1);
        send_byte(25'd6, 8'h55);
        send_byte(25'd9, 8'h66);
        set_dl(1'b0);
        drain("t3_drain");
        check_eq("t3_count", wr_log.size(), 2);
        check_log("t3_w0", 0, {24'd3, 16'h0055, 2'b01});
        check_log("t3_w1", 1, {24'd4, 16'h6600, 2'b10});

        // Ack withheld: FIFO fills, extra words dropped, request held stable
        wr_log.delete();
        ack_en   = 1'b0;
        watch    = 1'b1;
        req_seen = 1'b0;
        unstable = 0;
        set_dl(1'b1);
        for (int i = 0; i < 20; i++) send_byte(25'(i), 8'(i));
        tick(3);
        check_eq("t4_req", prog_req, 1'b1);
        check_eq("t4_head", {prog_addr, prog_data, prog_be}, {24'd0, 16'h0100, 2'b11});
        check_eq("t4_ovf", overflow, ExpOvf);
        check_eq("t4_stable", unstable, 0);
        watch = 1'b0;
        set_dl(1'b0);
        ack_en = 1'b1;
        drain("t4_drain");
        check_eq("t4_count", wr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_log($sformatf("t4_w%0d", i), i, {24'(i), 8'(2 * i + 1), 8'(2 * i), 2'b11});
        end
        check_eq("t4_ovf_sticky", overflow, ExpOvf);

        // Reset with an outstanding request and three queued words
        wr_log.delete();
        ack_en = 1'b0;
        set_dl(1'b1);
        for (int i = 0; i < 6; i++) send_byte(25'(i), 8'hA0 + 8'(i));
        set_dl(1'b0);
        tick(3);
        check_eq("t5_pre_req", prog_req, 1'b1);
        done_cnt = 0;
        @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        check_eq("t5_req", prog_req, 1'b0);
        check_eq("t5_busy", busy, 1'b0);
        rst    = 1'b0;
        ack_en = 1'b1;
        tick(20);
        check_eq("t5_no_writes", wr_log.size(), 0);
        check_eq("t5_no_done", done_cnt, 0);
        check_eq("t5_ovf_clr", overflow, 1'b0);

`ifdef IOCTL_PROM_EN
        wr_log.delete();
        prom_cnt = 0;
        set_dl(1'b1);
        send_byte(25'd18, 8'h7E);
        set_dl(1'b0);
        drain("t6_drain");
        check_eq("t6_prom_cnt", prom_cnt, 1);
        check_eq("t6_prom_addr", prom_a_seen, 25'd2);
        check_eq("t6_prom_data", prom_d_seen, 8'h7E);
        check_eq("t6_no_sdram", wr_log.size(), 0);
`else
        check_eq("t6_prom_idle", prom_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
